// File: rtl/vga_layer_mixer.sv
// rtl/vga_layer_mixer.sv - VGA timing generator, layer priority mux and sync/blank alignment
module vga_layer_mixer #(
  parameter int       N_LAYERS  = 4,
  parameter int       LAYER_LAT = 1,
  parameter logic [2:0] BG_RGB  = 3'b000,
  parameter int       H_VIS     = 800,
  parameter int       H_FP      = 40,
  parameter int       H_SYNC    = 128,
  parameter int       H_BP      = 88,
  parameter int       V_VIS     = 600,
  parameter int       V_FP      = 1,
  parameter int       V_SYNC    = 4,
  parameter int       V_BP      = 23,
  parameter logic     SYNC_POL  = 1'b1
) (
  input  logic                    vga_clk,
  input  logic                    rst,
  output logic [10:0]             x,
  output logic [9:0]              y,
  output logic                    frame_start,
  output logic [7:0]              frame_cnt,
  input  logic [3*N_LAYERS-1:0]   layer_rgb,
  input  logic [N_LAYERS-1:0]     layer_dav,
  output logic [2:0]              vga_rgb,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic                    vga_de
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  logic [10:0] r_x;
  logic [9:0]  r_y;
  logic [7:0]  r_frame_cnt;
  logic        w_x_last;
  logic        w_y_last;

  assign w_x_last = (r_x == 11'(H_TOT - 1));
  assign w_y_last = (r_y == 10'(V_TOT - 1));

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_x         <= '0;
      r_y         <= '0;
      r_frame_cnt <= '0;
    end else if (w_x_last) begin
      r_x <= '0;
      if (w_y_last) begin
        r_y         <= '0;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end else begin
        r_y <= r_y + 10'd1;
      end
    end else begin
      r_x <= r_x + 11'd1;
    end
  end

  assign x         = r_x;
  assign y         = r_y;
  assign frame_cnt = r_frame_cnt;
  // Decoded from the registered counters; masked while rst is held so it reads 0 in reset
  // yet is already high in the first released cycle, when x/y sit at the origin.
  assign frame_start = (r_x == 11'd0) && (r_y == 10'd0) && !rst;

  logic w_de0;
  logic w_hs0;
  logic w_vs0;

  assign w_de0 = (r_x < 11'(H_VIS)) && (r_y < 10'(V_VIS));
  assign w_hs0 = (r_x >= 11'(H_VIS + H_FP)) && (r_x < 11'(H_VIS + H_FP + H_SYNC));
  assign w_vs0 = (r_y >= 10'(V_VIS + V_FP)) && (r_y < 10'(V_VIS + V_FP + V_SYNC));

  // Each stage holds {de, hs, vs}, active-high regardless of SYNC_POL.
  logic [2:0] r_pipe [LAYER_LAT];

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      for (int i = 0; i < LAYER_LAT; i++) r_pipe[i] <= 3'b000;
    end else begin
      r_pipe[0] <= {w_de0, w_hs0, w_vs0};
      for (int i = 1; i < LAYER_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  logic [2:0] w_pix;

  always_comb begin
    w_pix = BG_RGB;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (layer_dav[i]) w_pix = layer_rgb[3*i +: 3];
    end
  end

  logic [2:0] r_rgb;
  logic       r_de;
  logic       r_hsync;
  logic       r_vsync;
  logic [2:0] w_d;

  assign w_d = r_pipe[LAYER_LAT-1];

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_rgb   <= 3'b000;
      r_de    <= 1'b0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
    end else begin
      r_rgb   <= w_d[2] ? w_pix : 3'b000;
      r_de    <= w_d[2];
      r_hsync <= w_d[1] ? SYNC_POL : ~SYNC_POL;
      r_vsync <= w_d[0] ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign vga_rgb   = r_rgb;
  assign vga_de    = r_de;
  assign vga_hsync = r_hsync;
  assign vga_vsync = r_vsync;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// tb/tb_vga_layer_mixer.sv - self-checking bench for vga_layer_mixer on a reduced raster
module tb_vga_layer_mixer;

  localparam int HV = 40, HF = 4, HS = 8, HB = 4;
  localparam int VV = 20, VF = 1, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int HS_FIRST = HV + HF + 2;

  logic        vga_clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] x;
  logic [9:0]  y;
  logic        frame_start;
  logic [7:0]  frame_cnt;
  logic [11:0] layer_rgb;
  logic [3:0]  layer_dav;
  logic [2:0]  vga_rgb;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_de;

  vga_layer_mixer #(
    .N_LAYERS(4), .LAYER_LAT(1), .BG_RGB(3'b000),
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1)
  ) dut (
    .vga_clk(vga_clk), .rst(rst), .x(x), .y(y),
    .frame_start(frame_start), .frame_cnt(frame_cnt),
    .layer_rgb(layer_rgb), .layer_dav(layer_dav),
    .vga_rgb(vga_rgb), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de)
  );

  initial forever #5 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         px;
    int         py;
    logic [3:0] dav;
    logic [11:0] rgb;
    logic [2:0] exp_rgb;
    logic       exp_de;
    bit         nb;
  } vec_t;

  vec_t vecs[10];

  // Layer model: presents the configured pixel one cycle after x/y showed it.
  bit          mode_all = 1'b0;
  int          cur_px = -1, cur_py = -1;
  logic [3:0]  cur_dav = '0;
  logic [11:0] cur_rgb = '0;
  int          lx = -1, ly = -1;

  initial begin
    layer_dav = '0;
    layer_rgb = '0;
    forever begin
      @(negedge vga_clk);
      if (mode_all) begin
        layer_dav = 4'b1111;
        layer_rgb = 12'hFFF;
      end else if (lx == cur_px && ly == cur_py) begin
        layer_dav = cur_dav;
        layer_rgb = cur_rgb;
      end else begin
        layer_dav = 4'b0000;
        layer_rgb = 12'($urandom);
      end
      lx = int'(x);
      ly = int'(y);
    end
  end

  task automatic wait_pixel(input int px, input int py, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < 3 * FRAME) begin
      @(negedge vga_clk);
      n++;
      if (int'(x) == px && int'(y) == py) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_pixel(%0d,%0d) actual=timeout required=reached", px, py);
    end
  endtask

  task automatic measure_hsync(input int start_k, input string tag);
    int k, w;
    k = start_k;
    while (vga_hsync !== 1'b1 && k < 2 * HT) begin
      @(negedge vga_clk);
      k++;
    end
    check({tag, "_hs_first"}, k, HS_FIRST);
    w = 0;
    while (vga_hsync === 1'b1 && w < 2 * HT) begin
      @(negedge vga_clk);
      w++;
    end
    check({tag, "_hs_width"}, w, HS);
  endtask

  initial begin
    bit ok;
    int n, de_cnt, vs_cnt, hs_cnt, bad;

    vecs[0] = '{0,  0,  4'b0000, 12'b000_000_000_000, 3'b000, 1'b1, 1'b0};
    vecs[1] = '{40, 0,  4'b0001, 12'b000_000_000_111, 3'b000, 1'b0, 1'b0};
    vecs[2] = '{5,  3,  4'b0101, 12'b000_101_000_110, 3'b110, 1'b1, 1'b0};
    vecs[3] = '{6,  3,  4'b0100, 12'b000_101_000_110, 3'b101, 1'b1, 1'b0};
    vecs[4] = '{13, 12, 4'b0001, 12'b000_000_000_011, 3'b011, 1'b1, 1'b1};
    vecs[5] = '{20, 5,  4'b1110, 12'b111_100_010_000, 3'b010, 1'b1, 1'b0};
    vecs[6] = '{30, 7,  4'b1000, 12'b001_000_000_000, 3'b001, 1'b1, 1'b0};
    vecs[7] = '{45, 5,  4'b1111, 12'b111_111_111_111, 3'b000, 1'b0, 1'b0};
    vecs[8] = '{10, 22, 4'b0001, 12'b000_000_000_111, 3'b000, 1'b0, 1'b0};
    vecs[9] = '{39, 19, 4'b0010, 12'b000_000_110_000, 3'b110, 1'b1, 1'b0};

    repeat (3) @(negedge vga_clk);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_rgb", vga_rgb, 0);
    check("rst_de", vga_de, 0);
    check("rst_hsync", vga_hsync, 0);
    check("rst_vsync", vga_vsync, 0);

    // T1: release reset
    rst = 1'b0;
    #1;
    check("t1_x0", x, 0);
    check("t1_fs0", frame_start, 1);
    @(negedge vga_clk);
    check("t1_x1", x, 1);
    check("t1_fs1", frame_start, 0);
    measure_hsync(1, "t1");

    // T2/T5: frame period, counter, sync widths, blanking with all layers active
    n = 0;
    while (frame_start !== 1'b1 && n < 2 * FRAME) begin
      @(negedge vga_clk);
      n++;
    end
    mode_all = 1'b1;
    n = 0; de_cnt = 0; vs_cnt = 0; hs_cnt = 0; bad = 0;
    do begin
      @(negedge vga_clk);
      n++;
      if (vga_de === 1'b1) de_cnt++;
      if (vga_vsync === 1'b1) vs_cnt++;
      if (vga_hsync === 1'b1) hs_cnt++;
      if (vga_de === 1'b1 && vga_rgb !== 3'b111) bad++;
      if (vga_de !== 1'b1 && vga_rgb !== 3'b000) bad++;
    end while (frame_start !== 1'b1 && n < 2 * FRAME);
    mode_all = 1'b0;
    check("t2_period", n, FRAME);
    check("t2_frame_cnt", frame_cnt, 2);
    check("t2_vs_cycles", vs_cnt, VS * HT);
    check("t2_hs_cycles", hs_cnt, HS * VT);
    check("t5_de_cycles", de_cnt, HV * VV);
    check("t5_bad_pixels", bad, 0);

    // T3/T4 and boundaries: one marked pixel per vector
    for (int i = 0; i < 10; i++) begin
      cur_px = vecs[i].px;
      cur_py = vecs[i].py;
      cur_dav = vecs[i].dav;
      cur_rgb = vecs[i].rgb;
      wait_pixel(vecs[i].px, vecs[i].py, ok);
      if (ok) begin
        @(negedge vga_clk);
        if (vecs[i].nb) check($sformatf("v%0d_prev_nb", i), vga_rgb, 3'b000);
        @(negedge vga_clk);
        check($sformatf("v%0d_rgb", i), vga_rgb, vecs[i].exp_rgb);
        check($sformatf("v%0d_de", i), vga_de, vecs[i].exp_de);
        @(negedge vga_clk);
        if (vecs[i].nb) check($sformatf("v%0d_next_nb", i), vga_rgb, 3'b000);
      end
      cur_px = -1;
      cur_py = -1;
    end

    // T6: one-cycle reset mid-frame in the active area
    wait_pixel(25, 10, ok);
    rst = 1'b1;
    @(negedge vga_clk);
    rst = 1'b0;
    #1;
    check("t6_x0", x, 0);
    check("t6_y0", y, 0);
    check("t6_fs", frame_start, 1);
    check("t6_de0", vga_de, 0);
    check("t6_hs0", vga_hsync, 0);
    @(negedge vga_clk);
    check("t6_x1", x, 1);
    check("t6_de1", vga_de, 0);
    check("t6_vs1", vga_vsync, 0);
    @(negedge vga_clk);
    check("t6_de2", vga_de, 1);
    measure_hsync(2, "t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
